sega_pad_scanner: RTL and testbench

- Upstream stage of the ISA joystick port block: scans one Sega Mega Drive pad through its SEL line.
- Detects the pad type: none, 3-button or 6-button.
- Publishes a debounced 12-bit button vector plus a 2-bit type code, which the port block returns on ports 0x250..0x253.
- The port block instantiates one copy per connector.

---
 rtl/sega_pad_scanner.sv | 146 ++++++++++++++
 tb/tb_sega_pad_scanner.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sega_pad_scanner.sv
// Scans one Sega Mega Drive pad through SEL: detects none/3-button/6-button and publishes a 12-bit button vector.
// Optional `SJ_DEBOUNCE_EN: commit only when two consecutive frames produce the same {type, status}.
module sega_pad_scanner #(
    parameter int PHASE_DIV   = 143,
    parameter int IDLE_PHASES = 160
) (
    input  logic        clk14,
    input  logic        reset_n,
    input  logic        scan_en,
    input  logic [5:0]  sj,
    output logic        sj_sel,
    output logic [11:0] status,
    output logic [1:0]  sj_type,
    output logic        frame_done
);

    localparam int PW = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
    localparam int IW = (IDLE_PHASES > 1) ? $clog2(IDLE_PHASES) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_P0, S_P1, S_P2, S_P3, S_P4, S_P5, S_P6, S_P7
    } state_t;

    logic [5:0]    sj_meta;
    logic [5:0]    sj_sync;
    logic [5:0]    pressed;
    logic [PW-1:0] phase_cnt;
    logic [IW-1:0] idle_cnt;
    state_t        state;
    logic          present;
    logic          six;
    logic [11:0]   shadow;
    logic          phase_end;
    logic [13:0]   cand_new;

    // Synchroniser resets to "all released" so nothing looks pressed after reset.
    always_ff @(posedge clk14 or negedge reset_n) begin
        if (!reset_n) begin
            sj_meta <= 6'h3F;
            sj_sync <= 6'h3F;
        end else begin
            sj_meta <= sj;
            sj_sync <= sj_meta;
        end
    end

    assign pressed   = ~sj_sync;
    assign phase_end = (phase_cnt == PW'(PHASE_DIV - 1));
    assign cand_new  = present ? {(six ? 2'b10 : 2'b01), shadow} : 14'h0000;

`ifdef SJ_DEBOUNCE_EN
    logic [13:0] cand;
`endif

    always_ff @(posedge clk14 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            phase_cnt  <= '0;
            idle_cnt   <= '0;
            present    <= 1'b0;
            six        <= 1'b0;
            shadow     <= '0;
            sj_sel     <= 1'b1;
            status     <= '0;
            sj_type    <= 2'b00;
            frame_done <= 1'b0;
`ifdef SJ_DEBOUNCE_EN
            cand       <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            phase_cnt  <= phase_end ? '0 : phase_cnt + PW'(1);
            // All sampling and SEL changes happen at the end of a half-phase.
            if (phase_end) begin
                case (state)
                    S_IDLE: begin
                        if (idle_cnt == IW'(IDLE_PHASES - 1)) begin
                            idle_cnt <= '0;
                            if (scan_en) begin
                                state  <= S_P0;
                                sj_sel <= 1'b0;
                            end
                        end else begin
                            idle_cnt <= idle_cnt + IW'(1);
                        end
                    end
                    S_P0: begin
                        present    <= pressed[2] & pressed[3];
                        shadow[6]  <= pressed[4];
                        shadow[7]  <= pressed[5];
                        state      <= S_P1;
                        sj_sel     <= 1'b1;
                    end
                    S_P1: begin
                        shadow[5:0] <= pressed;
                        state       <= S_P2;
                        sj_sel      <= 1'b0;
                    end
                    S_P2: begin
                        state  <= S_P3;
                        sj_sel <= 1'b1;
                    end
                    S_P3: begin
                        state  <= S_P4;
                        sj_sel <= 1'b0;
                    end
                    S_P4: begin
                        six    <= present & (&pressed[3:0]);
                        state  <= S_P5;
                        sj_sel <= 1'b1;
                    end
                    S_P5: begin
                        // Extra buttons: Mode, Z, Y, X on pins 3, 0, 1, 2.
                        shadow[11:8] <= six ? {pressed[3], pressed[0], pressed[1], pressed[2]} : 4'h0;
                        state        <= S_P6;
                        sj_sel       <= 1'b0;
                    end
                    S_P6: begin
                        state  <= S_P7;
                        sj_sel <= 1'b1;
                    end
                    S_P7: begin
                        state <= S_IDLE;
`ifdef SJ_DEBOUNCE_EN
                        cand <= cand_new;
                        if (cand_new == cand) begin
                            status     <= cand_new[11:0];
                            sj_type    <= cand_new[13:12];
                            frame_done <= 1'b1;
                        end
`else
                        status     <= cand_new[11:0];
                        sj_type    <= cand_new[13:12];
                        frame_done <= 1'b1;
`endif
                    end
                    default: begin
                        state  <= S_IDLE;
                        sj_sel <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sega_pad_scanner.sv
// Scoreboard bench for sega_pad_scanner: a behavioural pad model drives sj, a pad-level reference predicts each commit.
module tb_sega_pad_scanner;

    localparam int PD    = 4;
    localparam int IP    = 4;
    localparam int FRAME = (8 + IP) * PD;

    logic        clk14   = 1'b0;
    logic        reset_n = 1'b0;
    logic        scan_en = 1'b0;
    logic [5:0]  sj;
    logic        sj_sel;
    logic [11:0] status;
    logic [1:0]  sj_type;
    logic        frame_done;

    int          n_vec = 0;
    int          n_err = 0;
    int          pad_kind = 0;       // 0 none, 1 three-button, 2 six-button
    logic [11:0] btn = '0;           // 1 = pressed, status bit order
    int          low_idx = 0;        // SEL low pulses seen by the pad in this frame
    int          high_run = 0;
    logic        sel_prev = 1'b1;
    logic [13:0] exp_q[$];
    logic [13:0] model_cand = '0;
    logic [13:0] model_out = '0;
    bit          disrupt = 1'b0;

    always #5 clk14 = ~clk14;

    sega_pad_scanner #(.PHASE_DIV(PD), .IDLE_PHASES(IP)) dut (
        .clk14      (clk14),
        .reset_n    (reset_n),
        .scan_en    (scan_en),
        .sj         (sj),
        .sj_sel     (sj_sel),
        .status     (status),
        .sj_type    (sj_type),
        .frame_done (frame_done)
    );

    // Pad behaviour as documented for Mega Drive controllers, in pressed-form then inverted onto the pins.
    function automatic logic [5:0] pad_pins(input int kind, input logic sel, input int idx, input logic [11:0] b);
        logic [5:0] p;
        if (kind == 0) return 6'h3F;
        if (sel) begin
            if (kind == 2 && idx == 3) p = {b[5], b[4], b[11], b[8], b[9], b[10]};
            else                       p = b[5:0];
        end else begin
            if (kind == 2 && idx == 3)      p = {b[7], b[6], 4'b1111};
            else if (kind == 2 && idx == 4) p = {b[7], b[6], 4'b0000};
            else                            p = {b[7], b[6], 2'b11, b[1], b[0]};
        end
        return ~p;
    endfunction

    function automatic logic [13:0] expected(input int kind, input logic [11:0] b);
        if (kind == 0) return 14'h0000;
        if (kind == 1) return {2'b01, 4'h0, b[7:0]};
        return {2'b10, b};
    endfunction

    always_comb sj = pad_pins(pad_kind, sj_sel, low_idx, btn);

    // The pad counts SEL low pulses and forgets the count after a long high stretch.
    always @(negedge clk14) begin
        if (sel_prev && !sj_sel) low_idx = low_idx + 1;
        if (sj_sel) high_run = high_run + 1;
        else        high_run = 0;
        if (high_run > 2 * PD) low_idx = 0;
        sel_prev = sj_sel;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    task automatic issue(input int kind, input logic [11:0] b);
        logic [13:0] e;
        pad_kind = kind;
        btn      = b;
        e        = expected(kind, b);
`ifdef SJ_DEBOUNCE_EN
        if (e == model_cand) begin
            exp_q.push_back(e);
            model_out = e;
        end
        model_cand = e;
`else
        exp_q.push_back(e);
        model_out = e;
`endif
    endtask

    task automatic issue_random();
        int          k;
        logic [11:0] b;
        if ($urandom_range(0, 2) == 0) begin
            issue(pad_kind, btn);
        end else begin
            k = $urandom_range(0, 5);
            k = (k == 0) ? 0 : ((k <= 2) ? 1 : 2);
            b = 12'($urandom);
            if (b[0] && b[1]) b[1] = 1'b0;
            issue(k, b);
        end
    endtask

    // Wait for entry into the half-phase identified by the pad's pulse count and SEL level.
    task automatic wait_phase(input string name, input int idx, input logic sel);
        bit ok;
        bit seen_off;
        ok = 1'b0;
        seen_off = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk14);
            #1;
            if (low_idx == idx && sj_sel == sel) begin
                if (seen_off) begin
                    ok = 1'b1;
                    break;
                end
            end else begin
                seen_off = 1'b1;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout_%s: phase not reached within %0d cycles", name, 4 * FRAME);
        end
    endtask

    task automatic release_and_time();
        int n;
        @(negedge clk14);
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(posedge clk14);
            n++;
            #1;
            if (!sj_sel) break;
        end
        check("first_p0_delay", 32'(n), 32'(IP * PD));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"},        32'(sj_sel),     32'h1);
        check({tag, "_status"},     32'(status),     32'h0);
        check({tag, "_type"},       32'(sj_type),    32'h0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    endtask

    // Monitor: pops one expectation per frame_done; also checks atomicity and frame period.
    int          cyc = 0;
    int          last_fd = -1;
    logic [13:0] prev_out = '0;
    always @(negedge clk14) begin
        logic [13:0] e;
        cyc++;
        if (!reset_n) begin
            last_fd  = -1;
            prev_out = '0;
        end else begin
            if ({sj_type, status} !== prev_out && !frame_done) begin
                n_err++;
                $display("FAIL atomic_update: got type=%0d status=0x%03h without frame_done, want 0x%04h held",
                         sj_type, status, prev_out);
            end
            prev_out = {sj_type, status};
            if (frame_done) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_commit: got type=%0d status=0x%03h, want no commit", sj_type, status);
                end else begin
                    e = exp_q.pop_front();
                    if ({sj_type, status} !== e) begin
                        n_err++;
                        $display("FAIL commit: got type=%0d status=0x%03h, want type=%0d status=0x%03h",
                                 sj_type, status, e[13:12], e[11:0]);
                    end else begin
                        $display("commit @%0d: type=%0d status=0x%03h", cyc, sj_type, status);
                    end
                end
                if (last_fd >= 0 && !disrupt) begin
                    n_vec++;
`ifdef SJ_DEBOUNCE_EN
                    if ((cyc - last_fd) % FRAME != 0) begin
`else
                    if ((cyc - last_fd) != FRAME) begin
`endif
                        n_err++;
                        $display("FAIL frame_period: got %0d cycles, want %0d", cyc - last_fd, FRAME);
                    end
                end
                disrupt = 1'b0;
                last_fd = cyc;
            end
        end
    end

    initial begin
        int n_fall;
        logic s_prev;

        scan_en = 1'b1;
        issue_random();
        repeat (3) @(negedge clk14);
        #1;
        check_reset_outputs("reset");
        release_and_time();

        for (int f = 0; f < 24; f++) begin
            wait_phase("p7", 4, 1'b1);
            issue_random();
        end

        // Start held on a 3-button pad, then reset during P3 of a later frame.
        for (int f = 0; f < 3; f++) begin
            wait_phase("p7", 4, 1'b1);
            issue(1, 12'h080);
        end
        wait_phase("p3", 2, 1'b1);
        check("pre_reset_outputs", 32'({sj_type, status}), 32'h1080);
        @(negedge clk14);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        exp_q.delete();
        model_cand = '0;
        model_out  = '0;
        repeat (5) @(negedge clk14);
        issue_random();
        release_and_time();

        for (int f = 0; f < 4; f++) begin
            wait_phase("p7", 4, 1'b1);
            issue_random();
        end

        // Drop scan_en in P2: this frame commits, then SEL stays high and outputs freeze.
        wait_phase("p2", 2, 1'b0);
        scan_en = 1'b0;
        wait_phase("p7", 4, 1'b1);
        n_fall = 0;
        s_prev = sj_sel;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk14);
            #1;
            if (s_prev && !sj_sel) n_fall++;
            s_prev = sj_sel;
        end
        check("paused_sel_pulses", 32'(n_fall), 32'h0);
        check("paused_outputs", 32'({sj_type, status}), 32'(model_out));
        issue(2, 12'h900);
        disrupt = 1'b1;
        scan_en = 1'b1;

        for (int f = 0; f < 5; f++) begin
            wait_phase("p7", 4, 1'b1);
            if (f < 4) issue_random();
        end

        for (int i = 0; i < 4 * FRAME && exp_q.size() != 0; i++) @(negedge clk14);
        repeat (2) @(negedge clk14);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
